// File: rtl/adder_operand_loader_pkg.sv
// -----------------------------------------------------------------------------
// adder_operand_loader_pkg
//   Shared definitions for the operand loader that feeds the four-operand adder.
//   Holds the FSM state encoding, default operand width, operand count and the
//   width of the word counter, plus a small helper that flags the final word of
//   a set.
// -----------------------------------------------------------------------------
package adder_operand_loader_pkg;

  // COLLECT: gathering serial words; PRESENT: complete set held on outputs.
  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam int W_DEF   = 4;
  localparam int N_OPS   = 4;
  localparam int CNT_W   = 2;
  // The last operand bypasses the slot buffer and goes straight to out_d,
  // so only N_OPS-1 slots are stored.
  localparam int N_SLOTS = N_OPS - 1;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_OPS - 1);

  function automatic logic is_last_word(input logic [CNT_W-1:0] cnt);
    return (cnt == LAST_IDX);
  endfunction

endpackage

// File: rtl/adder_operand_loader_slot_buffer.sv
// -----------------------------------------------------------------------------
// loader_slot_buffer
//   Write-indexed register file holding the first N_SLOTS words of a set while
//   the remaining word is still outstanding. Reads are unregistered: every slot
//   is visible in parallel so the top level can copy the whole set on the edge
//   that accepts the final word.
//
// Ports
//   clk      : system clock, rising edge
//   res      : asynchronous active-low reset, clears every slot
//   we_i     : write enable
//   widx_i   : slot index to write (indices >= N_SLOTS are ignored)
//   wdata_i  : word to store
//   slot_o   : all stored slots, slot_o[0] is the first word of the set
// -----------------------------------------------------------------------------
module loader_slot_buffer
  import adder_operand_loader_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          we_i,
  input  logic [CNT_W-1:0]              widx_i,
  input  logic [W-1:0]                  wdata_i,
  output logic [N_SLOTS-1:0][W-1:0]     slot_o
);

  logic [N_SLOTS-1:0][W-1:0] slot_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      slot_q <= '0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        if (we_i && (widx_i == CNT_W'(i))) begin
          slot_q[i] <= wdata_i;
        end
      end
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/adder_operand_loader.sv
// -----------------------------------------------------------------------------
// adder_operand_loader
//   Upstream stage of the four-operand adder. Collects W-bit operand words from
//   a serial valid/ready stream and presents them as one parallel set (A..D)
//   under an out_valid/out_ready handshake. Data passes through bit-exact.
//
// Ports
//   clk       : system clock, rising edge
//   res       : asynchronous active-low reset
//   flush     : synchronous abort of a partial or pending set
//   in_data   : serial operand word
//   in_valid  : in_data valid
//   in_ready  : loader accepts in_data this cycle (high only while collecting)
//   out_a..d  : operand set, A is the first word accepted
//   out_valid : out_a..out_d hold a complete set
//   out_ready : downstream consumes the set this cycle
//   busy      : at least one word of a new set has been captured
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   COLLECT | accepting words into slots; outputs hold the previous set
//   PRESENT | complete set on out_a..out_d, waiting for out_ready
// -----------------------------------------------------------------------------
module adder_operand_loader
  import adder_operand_loader_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         res,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic [W-1:0] out_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [W-1:0]              out_a_q;
  logic [W-1:0]              out_b_q;
  logic [W-1:0]              out_c_q;
  logic [W-1:0]              out_d_q;
  logic                      out_valid_q;
  logic                      busy_q;

  logic                      accept;
  logic                      slot_we;
  logic [N_SLOTS-1:0][W-1:0] slot;

  // in_ready is a pure decode of the state register, so it is glitch-free and
  // already 1 as soon as reset releases.
  assign in_ready = (state_q == COLLECT);
  assign accept   = in_valid && in_ready;

  // A flushed accept must not leave a stale word behind; the final word never
  // needs a slot because it is routed straight to out_d.
  assign slot_we  = accept && !flush && !is_last_word(cnt_q);

  loader_slot_buffer #(
    .W (W)
  ) u_slot_buffer (
    .clk     (clk),
    .res     (res),
    .we_i    (slot_we),
    .widx_i  (cnt_q),
    .wdata_i (in_data),
    .slot_o  (slot)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_d_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      // Output operands deliberately keep the last completed set.
      state_q     <= COLLECT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (is_last_word(cnt_q)) begin
              out_a_q     <= slot[0];
              out_b_q     <= slot[1];
              out_c_q     <= slot[2];
              out_d_q     <= in_data;
              cnt_q       <= '0;
              state_q     <= PRESENT;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              cnt_q  <= cnt_q + CNT_W'(1);
              busy_q <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= COLLECT;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign out_d     = out_d_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
module tb_adder_operand_loader;

  logic       clk;
  logic       res;
  logic       flush;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_a;
  logic [3:0] out_b;
  logic [3:0] out_c;
  logic [3:0] out_d;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_assert;
  int n_fail;
  int n_hs;

  logic [15:0] sb[$];
  logic [15:0] last_set;

  adder_operand_loader #(.W(4)) dut (
    .clk       (clk),
    .res       (res),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: a handshake occurs on the next rising edge whenever
  // out_valid and out_ready are both high; the set must match the oldest push.
  always @(negedge clk) begin
    #2;
    if (res && out_valid && out_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        check("handshake_set", {out_a, out_b, out_c, out_d}, sb.pop_front());
      end
    end
  end

  task automatic send_word(input logic [3:0] d);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic send_set(input logic [15:0] s, input int gap);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("pre_last_valid", out_valid, 1'b0);
      send_word(s[15-4*i -: 4]);
      if (i < 3) begin
        check("busy_mid", busy, 1'b1);
        check("hold_outs_mid", {out_a, out_b, out_c, out_d}, last_set);
        if (gap > 0) begin
          in_valid = 1'b0;
          repeat (gap) begin
            @(negedge clk);
            check("gap_busy", busy, 1'b1);
            check("gap_valid", out_valid, 1'b0);
          end
        end
      end
    end
    sb.push_back(s);
    last_set = s;
    check("latency_valid", out_valid, 1'b1);
    check("done_busy", busy, 1'b0);
    check("present_ready", in_ready, 1'b0);
    check("present_outs", {out_a, out_b, out_c, out_d}, s);
  endtask

  task automatic consume();
    int guard;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("consume_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", out_valid, 1'b0);
    check("post_hs_ready", in_ready, 1'b1);
    check("post_hs_outs", {out_a, out_b, out_c, out_d}, last_set);
  endtask

  initial begin
    logic [3:0] words [8];
    int idx;
    int first;
    int second;
    logic prev_v;
    logic acc;

    n_assert  = 0;
    n_fail    = 0;
    n_hs      = 0;
    res       = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    last_set  = '0;

    // Reset values
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_outs", {out_a, out_b, out_c, out_d}, 16'h0000);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", in_ready, 1'b1);

    // Reset mid-collection drops the partial set
    send_word(4'h5);
    send_word(4'h6);
    in_valid = 1'b0;
    check("mid_busy", busy, 1'b1);
    #1 res = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_outs", {out_a, out_b, out_c, out_d}, 16'h0000);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_busy2", busy, 1'b0);

    // Basic load with in_valid held high, then backpressure
    send_set(16'h1234, 0);
    in_valid = 1'b1;
    in_data  = 4'hF;
    repeat (10) begin
      @(negedge clk);
      check("bp_ready", in_ready, 1'b0);
      check("bp_valid", out_valid, 1'b1);
      check("bp_outs", {out_a, out_b, out_c, out_d}, 16'h1234);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_hs_valid", out_valid, 1'b0);
    check("bp_hs_ready", in_ready, 1'b1);
    check("bp_hs_busy", busy, 1'b0);
    check("bp_hs_outs", {out_a, out_b, out_c, out_d}, 16'h1234);

    // Gapped input
    send_set(16'hABCD, 3);
    in_valid = 1'b0;
    consume();

    // Flush with a simultaneous accept
    send_word(4'h7);
    send_word(4'h8);
    in_valid = 1'b1;
    in_data  = 4'h9;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_outs", {out_a, out_b, out_c, out_d}, 16'hABCD);
    send_set(16'h1234, 0);
    in_valid = 1'b0;
    consume();

    // Back-to-back sets with out_ready raised as soon as out_valid is seen
    words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3; words[3] = 4'h4;
    words[4] = 4'h5; words[5] = 4'h6; words[6] = 4'h7; words[7] = 4'h8;
    sb.push_back(16'h1234);
    sb.push_back(16'h5678);
    idx    = 0;
    first  = -1;
    second = -1;
    prev_v = out_valid;
    for (int k = 0; k < 20; k++) begin
      if (out_valid && !prev_v) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      prev_v    = out_valid;
      out_ready = out_valid;
      if (idx < 8) begin
        in_valid = 1'b1;
        in_data  = words[idx];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    last_set  = 16'h5678;
    check("b2b_words", 32'(idx), 32'd8);
    check("b2b_spacing", 32'(second - first), 32'd5);
    check("b2b_outs", {out_a, out_b, out_c, out_d}, 16'h5678);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("hs_count", 32'(n_hs), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
